if_fetch_unit: RTL and testbench

//   Instruction-fetch producer for the IF/ID pipeline register. Owns the PC and issues

---
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for IF/ID: owns the PC, one outstanding imem request at a time.
// Optional IF_MISALIGN_TRAP_EN adds a sticky fetch_misaligned flag that blocks fetches from unaligned PCs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  state_e      state_r;
  logic [31:0] pc_r;
  logic        kill_r;
  logic        if_valid_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_instr_r;
  logic        pc_ok_s;
  logic        req_fire_s;

`ifdef IF_MISALIGN_TRAP_EN
  logic        misaligned_r;
  assign pc_ok_s          = (pc_r[1:0] == 2'b00);
  assign fetch_misaligned = misaligned_r;
`else
  assign pc_ok_s          = 1'b1;
`endif

  // Request is combinational on state so it drops the moment reset asserts.
  assign imem_req_valid = rst_n && (state_r == ST_REQ) && pc_ok_s;
  assign imem_addr      = pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  assign if_valid       = if_valid_r;
  assign if_pc          = if_pc_r;
  assign if_instruction = if_instr_r;

  // Fetch FSM, PC and the IF/ID-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      kill_r       <= 1'b0;
      if_valid_r   <= 1'b0;
      if_pc_r      <= 32'h0000_0000;
      if_instr_r   <= NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
      misaligned_r <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_r         <= redirect_pc;
      if_valid_r   <= 1'b0;
      if_instr_r   <= NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
      misaligned_r <= 1'b0;
`endif
      // An accepted or in-flight request belongs to the old path: mark it for dropping.
      case (state_r)
        ST_REQ: begin
          if (req_fire_s) begin
            state_r <= ST_WAIT;
            kill_r  <= 1'b1;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_r <= ST_REQ;
            kill_r  <= 1'b0;
          end else begin
            kill_r  <= 1'b1;
          end
        end
        ST_OUT: begin
          state_r <= ST_REQ;
        end
        default: begin
          state_r <= ST_REQ;
          kill_r  <= 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        ST_REQ: begin
          if (req_fire_s) begin
            state_r <= ST_WAIT;
          end
`ifdef IF_MISALIGN_TRAP_EN
          if (!pc_ok_s) begin
            misaligned_r <= 1'b1;
          end
`endif
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (kill_r) begin
              kill_r  <= 1'b0;
              state_r <= ST_REQ;
            end else begin
              if_pc_r    <= pc_r;
              if_instr_r <= imem_rsp_data;
              if_valid_r <= 1'b1;
              pc_r       <= pc_r + PC_STEP;
              state_r    <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (!stall) begin
            if_valid_r <= 1'b0;
            if_instr_r <= NOP_INSTR;
            state_r    <= ST_REQ;
          end
        end
        default: begin
          state_r <= ST_REQ;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a negedge memory model answers requests with
// address-derived words; each test pushes the instructions it expects to see presented.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
`ifdef IF_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  int          mem_cnt = 0;
  int          rsp_count = 0;
  logic [31:0] mem_addr_q = 32'h0;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0] ^ 16'h0F0F};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_data(pc);
    return e;
  endfunction

  // Memory: handshake seen mid-cycle completes at next posedge; response lat cycles after that.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_data(mem_addr_q);
          rsp_count++;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_addr_q = imem_addr;
        mem_cnt    = lat + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: req_valid=%b if_valid=%b, required 0 0", imem_req_valid, if_valid);
    end
    checks++;
    if (if_pc !== 32'h0 || if_instruction !== NOP || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_data: if_pc=%h instr=%h addr=%h, required 0 %h 0", if_pc, if_instruction, imem_addr, NOP);
    end
`ifdef IF_MISALIGN_TRAP_EN
    checks++;
    if (fetch_misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_misaligned: got %b, required 0", fetch_misaligned);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_sequential;
    exp_t e;
    int cyc = 0, last = -1, seen = 0;
    sb.push_back(mk(32'h0)); sb.push_back(mk(32'h4)); sb.push_back(mk(32'h8));
    while (seen < 3 && cyc < 30) begin
      @(negedge clk); cyc++;
      if (if_valid) begin
        e = sb.pop_front(); checks++;
        if (if_pc !== e.pc || if_instruction !== e.instr) begin
          errors++; $display("FAIL seq_data: pc=%h instr=%h, required %h %h", if_pc, if_instruction, e.pc, e.instr);
        end
        checks++;
        if ((last < 0 && cyc != 2) || (last >= 0 && cyc - last != 3)) begin
          errors++; $display("FAIL seq_timing: valid at cycle %0d (prev %0d), required 2 then every 3", cyc, last);
        end
        last = cyc; seen++;
      end else begin
        checks++;
        if (if_instruction !== NOP) begin
          errors++; $display("FAIL seq_nop: instr=%h while invalid, required %h", if_instruction, NOP);
        end
      end
    end
    checks++;
    if (seen != 3) begin
      errors++; $display("FAIL seq_timeout: %0d presented, required 3", seen);
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instruction !== mem_data(32'h8) || imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold: v=%b pc=%h instr=%h req=%b, required 1 8 %h 0", if_valid, if_pc, if_instruction, imem_req_valid, mem_data(32'h8));
      end
    end
    stall = 1'b0;
    @(negedge clk); checks++;
    if (if_valid !== 1'b0 || if_instruction !== NOP || imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin
      errors++; $display("FAIL stall_release: v=%b instr=%h req=%b addr=%h, required 0 %h 1 c", if_valid, if_instruction, imem_req_valid, imem_addr, NOP);
    end
  endtask

  task automatic test_redirect_wait;
    exp_t e;
    int got = 0, found = 0;
    sb.push_back(mk(32'hC));
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (if_valid && sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (if_pc !== e.pc || if_instruction !== e.instr) begin
          errors++; $display("FAIL redir_pre: pc=%h instr=%h, required %h %h", if_pc, if_instruction, e.pc, e.instr);
        end
      end
      if (imem_req_valid && imem_addr == 32'h10) found = 1;
    end
    lat = 3;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100; lat = 0;
    @(negedge clk);
    redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      checks++;
      if (if_valid !== 1'b0) begin
        errors++; $display("FAIL redir_squash: if_valid=%b pc=%h, required 0", if_valid, if_pc);
      end
      if (imem_req_valid) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (found == 0 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_addr: req=%b addr=%h, required 1 100", imem_req_valid, imem_addr);
    end
    sb.push_back(mk(32'h100));
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1; e = sb.pop_front(); checks++;
        if (if_pc !== e.pc || if_instruction !== e.instr) begin
          errors++; $display("FAIL redir_target: pc=%h instr=%h, required %h %h", if_pc, if_instruction, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL redir_timeout: no presentation, required pc 100"); end
  endtask

  task automatic test_redirect_stall;
    exp_t e;
    int got = 0;
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || if_instruction !== NOP || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL redir_stall: v=%b instr=%h req=%b addr=%h, required 0 %h 1 200", if_valid, if_instruction, imem_req_valid, imem_addr, NOP);
    end
    sb.push_back(mk(32'h200));
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1; e = sb.pop_front(); checks++;
        if (if_pc !== e.pc || if_instruction !== e.instr) begin
          errors++; $display("FAIL redir_stall_data: pc=%h instr=%h, required %h %h", if_pc, if_instruction, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL redir_stall_timeout: no presentation, required pc 200"); end
  endtask

  task automatic test_reset_midfetch;
    exp_t e;
    int got = 0, rsp_before;
    for (int i = 0; i < 10 && imem_req_valid !== 1'b1; i++) @(negedge clk);
    lat = 2;
    @(negedge clk);
    rsp_before = rsp_count;
    rst_n = 1'b0;
    #2;
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h0 || if_instruction !== NOP) begin
      errors++; $display("FAIL midreset_state: v=%b req=%b addr=%h instr=%h, required 0 0 0 %h", if_valid, imem_req_valid, imem_addr, if_instruction, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1; imem_req_ready = 1'b0; lat = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_count == rsp_before || if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL midreset_stale: rsps=%0d v=%b req=%b addr=%h, required >%0d 0 1 0", rsp_count, if_valid, imem_req_valid, imem_addr, rsp_before);
    end
    imem_req_ready = 1'b1;
    sb.push_back(mk(32'h0));
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1; e = sb.pop_front(); checks++;
        if (if_pc !== e.pc || if_instruction !== e.instr) begin
          errors++; $display("FAIL midreset_data: pc=%h instr=%h, required %h %h", if_pc, if_instruction, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL midreset_timeout: no presentation, required pc 0"); end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int got = 0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold: req=%b addr=%h v=%b, required 1 4 0", imem_req_valid, imem_addr, if_valid);
      end
    end
    imem_req_ready = 1'b1;
    sb.push_back(mk(32'h4));
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1; e = sb.pop_front(); checks++;
        if (if_pc !== e.pc || if_instruction !== e.instr) begin
          errors++; $display("FAIL bp_data: pc=%h instr=%h, required %h %h", if_pc, if_instruction, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL bp_timeout: no presentation, required pc 4"); end
  endtask

  task automatic test_back_to_back_wrap;
    exp_t e;
    int seen = 0, found = 0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    sb.push_back(mk(32'hFFFF_FFFC)); sb.push_back(mk(32'h0));
    for (int i = 0; i < 20 && seen < 2; i++) begin
      @(negedge clk);
      if (if_valid && sb.size() > 0) begin
        e = sb.pop_front(); seen++; checks++;
        if (if_pc !== e.pc || if_instruction !== e.instr) begin
          errors++; $display("FAIL wrap_data: pc=%h instr=%h, required %h %h", if_pc, if_instruction, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (seen != 2) begin errors++; $display("FAIL wrap_timeout: %0d presented, required 2", seen); end
    for (int i = 0; i < 6 && found == 0; i++) begin
      @(negedge clk);
      if (imem_req_valid) found = 1;
    end
    checks++;
    if (found == 0 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL wrap_next: req=%b addr=%h, required 1 4", imem_req_valid, imem_addr);
    end
  endtask

`ifdef IF_MISALIGN_TRAP_EN
  task automatic test_misaligned;
    exp_t e;
    int got = 0, found = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      checks++;
      if (if_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: if_valid=%b, required 0", if_valid); end
      if (fetch_misaligned === 1'b1) found = 1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL mis_sticky: flag=%b req=%b v=%b, required 1 0 0", fetch_misaligned, imem_req_valid, if_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL mis_clear: flag=%b req=%b addr=%h, required 0 1 200", fetch_misaligned, imem_req_valid, imem_addr);
    end
    sb.push_back(mk(32'h200));
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1; e = sb.pop_front(); checks++;
        if (if_pc !== e.pc || if_instruction !== e.instr) begin
          errors++; $display("FAIL mis_resume: pc=%h instr=%h, required %h %h", if_pc, if_instruction, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL mis_timeout: no presentation, required pc 200"); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_reset_midfetch();
    test_backpressure();
    test_back_to_back_wrap();
`ifdef IF_MISALIGN_TRAP_EN
    test_misaligned();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
